// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: WB writes win over long-latency unit results,
// a busy scoreboard stalls decode on outstanding LLU destinations, and a starvation
// counter asks the pipeline to hold WB so the LLU eventually gets the port.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int REG_NUM    = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic [XLEN-1:0] wb_rd_data_i,
  input  logic            llu_valid_i,
  output logic            llu_ready_o,
  input  logic [4:0]      llu_rd_addr_i,
  input  logic [XLEN-1:0] llu_rd_data_i,
  input  logic            iss_valid_i,
  input  logic [4:0]      iss_rd_addr_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      dec_rd_addr_i,
  output logic            stall_o,
  output logic            wb_hold_o,
  output logic            rd_we_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  localparam logic [CNT_W-1:0] LP_STARVE_MAX = CNT_W'(STARVE_MAX);

  logic [REG_NUM-1:0] r_busy;
  logic [CNT_W-1:0]   r_starveCnt;

  logic [REG_NUM-1:0] w_busyNext;
  logic [CNT_W-1:0]   w_starveNext;
  logic               w_wbAct;
  logic               w_lluHs;
  logic               w_lluStarved;

  assign w_wbAct = wb_we_i && (wb_rd_addr_i != 5'd0);

  // WB always wins the port; the LLU is offered the port whenever WB is idle,
  // and a handshake to x0 completes without touching the regfile.
  always_comb begin
    llu_ready_o = 1'b0;
    rd_we_o     = 1'b0;
    rd_addr_o   = 5'd0;
    rd_data_o   = '0;
    if (!rst_i) begin
      if (w_wbAct) begin
        rd_we_o   = 1'b1;
        rd_addr_o = wb_rd_addr_i;
        rd_data_o = wb_rd_data_i;
      end else begin
        llu_ready_o = 1'b1;
        if (llu_valid_i && (llu_rd_addr_i != 5'd0)) begin
          rd_we_o   = 1'b1;
          rd_addr_o = llu_rd_addr_i;
          rd_data_o = llu_rd_data_i;
        end
      end
    end
  end

  assign w_lluHs      = llu_valid_i && llu_ready_o;
  assign w_lluStarved = llu_valid_i && !llu_ready_o;

  // Clear is applied before set so a back-to-back issue to the same register stays busy.
  always_comb begin
    w_busyNext = r_busy;
    if (w_lluHs && (llu_rd_addr_i != 5'd0)) begin
      w_busyNext[llu_rd_addr_i] = 1'b0;
    end
    if (iss_valid_i && (iss_rd_addr_i != 5'd0)) begin
      w_busyNext[iss_rd_addr_i] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  always_comb begin
    w_starveNext = '0;
    if (w_lluStarved) begin
      w_starveNext = (r_starveCnt == LP_STARVE_MAX) ? r_starveCnt : r_starveCnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy      <= '0;
      r_starveCnt <= '0;
    end else begin
      r_busy      <= w_busyNext;
      r_starveCnt <= w_starveNext;
    end
  end

  assign stall_o   = !rst_i && (r_busy[rs1_addr_i] || r_busy[rs2_addr_i] || r_busy[dec_rd_addr_i]);
  assign wb_hold_o = (r_starveCnt == LP_STARVE_MAX);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios followed by randomized traffic,
// all compared against a register-level reference model of the arbiter rules.
module tb_regfile_wb_arbiter;

  localparam int XLEN       = 32;
  localparam int REG_NUM    = 32;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            wb_we_i;
  logic [4:0]      wb_rd_addr_i;
  logic [XLEN-1:0] wb_rd_data_i;
  logic            llu_valid_i;
  logic            llu_ready_o;
  logic [4:0]      llu_rd_addr_i;
  logic [XLEN-1:0] llu_rd_data_i;
  logic            iss_valid_i;
  logic [4:0]      iss_rd_addr_i;
  logic [4:0]      rs1_addr_i;
  logic [4:0]      rs2_addr_i;
  logic [4:0]      dec_rd_addr_i;
  logic            stall_o;
  logic            wb_hold_o;
  logic            rd_we_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;

  int checks = 0;
  int errors = 0;

  bit mBusy [REG_NUM];
  int mStarve;

  regfile_wb_arbiter #(
    .XLEN(XLEN), .REG_NUM(REG_NUM), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_we_i(wb_we_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
    .llu_valid_i(llu_valid_i), .llu_ready_o(llu_ready_o),
    .llu_rd_addr_i(llu_rd_addr_i), .llu_rd_data_i(llu_rd_data_i),
    .iss_valid_i(iss_valid_i), .iss_rd_addr_i(iss_rd_addr_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .dec_rd_addr_i(dec_rd_addr_i),
    .stall_o(stall_o), .wb_hold_o(wb_hold_o),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Single point of comparison: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one cycle's inputs shortly after the falling edge and lets them settle.
  task automatic applyStimulus(input logic wbWe, input logic [4:0] wbAddr, input logic [XLEN-1:0] wbData,
                               input logic lv, input logic [4:0] la, input logic [XLEN-1:0] ld,
                               input logic iv, input logic [4:0] ia,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dr);
    wb_we_i       = wbWe;
    wb_rd_addr_i  = wbAddr;
    wb_rd_data_i  = wbData;
    llu_valid_i   = lv;
    llu_rd_addr_i = la;
    llu_rd_data_i = ld;
    iss_valid_i   = iv;
    iss_rd_addr_i = ia;
    rs1_addr_i    = r1;
    rs2_addr_i    = r2;
    dec_rd_addr_i = dr;
    #2;
  endtask

  function automatic bit modelReady();
    return !(wb_we_i && wb_rd_addr_i != 0);
  endfunction

  task automatic resetModel();
    foreach (mBusy[i]) mBusy[i] = 1'b0;
    mStarve = 0;
  endtask

  // Compares all outputs with the model, then advances the model across the rising edge.
  task automatic checkCycle();
    bit wbWins;
    bit lluWrites;
    bit expReady;
    bit expStall;
    bit hs;
    wbWins    = wb_we_i && wb_rd_addr_i != 0;
    expReady  = !wbWins;
    lluWrites = expReady && llu_valid_i && llu_rd_addr_i != 0;
    expStall  = mBusy[rs1_addr_i] || mBusy[rs2_addr_i] || mBusy[dec_rd_addr_i];
    checkOutput("llu_ready", {31'd0, llu_ready_o}, {31'd0, expReady});
    checkOutput("rd_we", {31'd0, rd_we_o}, {31'd0, wbWins || lluWrites});
    checkOutput("rd_addr", {27'd0, rd_addr_o},
                wbWins ? {27'd0, wb_rd_addr_i} : lluWrites ? {27'd0, llu_rd_addr_i} : 32'd0);
    checkOutput("rd_data", rd_data_o, wbWins ? wb_rd_data_i : lluWrites ? llu_rd_data_i : 32'd0);
    checkOutput("stall", {31'd0, stall_o}, {31'd0, expStall});
    checkOutput("wb_hold", {31'd0, wb_hold_o}, {31'd0, mStarve == STARVE_MAX});
    hs = llu_valid_i && expReady;
    @(posedge clk_i);
    if (hs && llu_rd_addr_i != 0) mBusy[llu_rd_addr_i] = 1'b0;
    if (iss_valid_i && iss_rd_addr_i != 0) mBusy[iss_rd_addr_i] = 1'b1;
    if (llu_valid_i && !expReady) mStarve = (mStarve + 1 > STARVE_MAX) ? STARVE_MAX : mStarve + 1;
    else mStarve = 0;
    @(negedge clk_i);
  endtask

  task automatic idleCycle(input logic [4:0] r1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, r1, 0, 0);
    checkCycle();
  endtask

  logic            pendValid;
  logic [4:0]      pendAddr;
  logic [XLEN-1:0] pendData;
  logic            rWbWe;

  initial begin
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetModel();
    checkOutput("rst_rd_we", {31'd0, rd_we_o}, 32'd0);
    checkOutput("rst_hold", {31'd0, wb_hold_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Busy register plus saturated starvation, then an asynchronous reset between edges.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    checkCycle();
    for (int i = 0; i < STARVE_MAX; i++) begin
      applyStimulus(1, 2, 32'h1111_0000 + i, 1, 6, 32'h66, 0, 0, 5, 0, 0);
      checkCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    checkOutput("pre_rst_hold", {31'd0, wb_hold_o}, 32'd1);
    checkOutput("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    #1 rst_i = 1'b1;
    #1;
    checkOutput("async_hold", {31'd0, wb_hold_o}, 32'd0);
    checkOutput("async_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("async_ready", {31'd0, llu_ready_o}, 32'd0);
    resetModel();
    @(negedge clk_i);
    rst_i = 1'b0;
    idleCycle(5);

    // RAW stall on x7 resolved by its LLU result.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    checkCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    checkOutput("raw_stall", {31'd0, stall_o}, 32'd1);
    checkCycle();
    applyStimulus(0, 0, 0, 1, 7, 32'hDEAD, 0, 0, 7, 0, 0);
    checkOutput("x7_addr", {27'd0, rd_addr_o}, 32'd7);
    checkOutput("x7_data", rd_data_o, 32'hDEAD);
    checkCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    checkOutput("raw_clear", {31'd0, stall_o}, 32'd0);
    checkCycle();

    // WB beats a simultaneous LLU result, which lands the following cycle.
    applyStimulus(1, 3, 32'h3333, 1, 9, 32'h9999, 0, 0, 0, 0, 0);
    checkOutput("wb_wins_addr", {27'd0, rd_addr_o}, 32'd3);
    checkOutput("wb_wins_ready", {31'd0, llu_ready_o}, 32'd0);
    checkCycle();
    applyStimulus(0, 0, 0, 1, 9, 32'h9999, 0, 0, 0, 0, 0);
    checkOutput("llu_after_addr", {27'd0, rd_addr_o}, 32'd9);
    checkCycle();

    // Starvation: hold rises in the fifth cycle, LLU gets the port once WB drops.
    for (int i = 0; i < STARVE_MAX; i++) begin
      applyStimulus(1, 10 + i, 32'hA0 + i, 1, 12, 32'hC0FFEE, 0, 0, 0, 0, 0);
      checkOutput("starve_hold_low", {31'd0, wb_hold_o}, 32'd0);
      checkCycle();
    end
    applyStimulus(1, 15, 32'hF5, 1, 12, 32'hC0FFEE, 0, 0, 0, 0, 0);
    checkOutput("starve_hold_high", {31'd0, wb_hold_o}, 32'd1);
    checkOutput("hold_wb_wins", {27'd0, rd_addr_o}, 32'd15);
    checkCycle();
    applyStimulus(0, 0, 0, 1, 12, 32'hC0FFEE, 0, 0, 0, 0, 0);
    checkOutput("starve_grant", {31'd0, llu_ready_o}, 32'd1);
    checkCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("starve_hold_clear", {31'd0, wb_hold_o}, 32'd0);
    checkCycle();

    // x0 traffic never writes, never blocks, never marks busy.
    applyStimulus(1, 0, 32'hBAD0, 1, 0, 32'hBAD1, 1, 0, 0, 0, 0);
    checkOutput("x0_we", {31'd0, rd_we_o}, 32'd0);
    checkOutput("x0_ready", {31'd0, llu_ready_o}, 32'd1);
    checkCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_stall", {31'd0, stall_o}, 32'd0);
    checkCycle();

    // Completion and re-issue to x4 in the same cycle keeps it busy.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    checkCycle();
    applyStimulus(0, 0, 0, 1, 4, 32'h44, 1, 4, 0, 0, 0);
    checkCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    checkOutput("x4_rebusy", {31'd0, stall_o}, 32'd1);
    checkCycle();
    applyStimulus(0, 0, 0, 1, 4, 32'h45, 0, 0, 0, 0, 4);
    checkCycle();
    idleCycle(4);

    // Randomized traffic with an LLU that holds its result until accepted.
    pendValid = 1'b0;
    pendAddr  = '0;
    pendData  = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pendValid && ($urandom_range(0, 2) != 0)) begin
        pendValid = 1'b1;
        pendAddr  = 5'($urandom_range(0, 7));
        pendData  = $urandom;
      end
      rWbWe = ($urandom_range(0, 9) < 6);
      if (wb_hold_o && ($urandom_range(0, 4) != 0)) rWbWe = 1'b0;
      applyStimulus(rWbWe, 5'($urandom_range(0, 7)), $urandom,
                    pendValid, pendAddr, pendData,
                    ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (pendValid && modelReady()) pendValid = 1'b0;
      checkCycle();
      if (c == 200) begin
        rst_i = 1'b1;
        #1;
        resetModel();
        pendValid = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
